// File: rtl/mod_muldiv.sv
// mod_muldiv: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// A one-cycle start launches MULT/MULTU/DIV/DIVU. busy stays high for a fixed
// latency, and then HI/LO are committed. MTHI/MTLO write immediately.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9).
//
// state | meaning
// IDLE  | unit free, busy=0, accepts start
// RUN   | operation in flight, counter running, busy=1
module mod_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    logic          mul_signed;
    logic [63:0]   mul_a, mul_b, prod;
    logic          div_signed;
    logic [31:0]   div_a_abs, div_b_abs, quo_u, rem_u, quo, rem;
`ifdef MULDIV_MADD_EN
    logic [63:0]   acc_add, acc_sub;
`endif

    // Datapath on latched operands only: the 64-bit product and the signed/unsigned quotient and remainder.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MULDIV_MADD_EN
        if (op_q == OP_MADD || op_q == OP_MSUB) begin
            mul_signed = 1'b1;
        end
`endif
        mul_a = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b = {{32{mul_signed & b_q[31]}}, b_q};
        // The low 64 bits of the sign-extended product are exact for both signednesses.
        prod  = mul_a * mul_b;

        div_signed = (op_q == OP_DIV);
        div_a_abs  = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        div_b_abs  = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        // Divide by zero yields garbage here. It is never committed.
        quo_u = (div_b_abs == 32'd0) ? 32'd0 : (div_a_abs / div_b_abs);
        rem_u = (div_b_abs == 32'd0) ? 32'd0 : (div_a_abs % div_b_abs);
        // Magnitude division plus sign fix-up gives truncation toward zero. It also makes
        // 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
        quo = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_u) : quo_u;
        rem = (div_signed && a_q[31]) ? (32'd0 - rem_u) : rem_u;
`ifdef MULDIV_MADD_EN
        acc_add = {hi_q, lo_q} + prod;
        acc_sub = {hi_q, lo_q} - prod;
`endif
    end

    // Next-state logic: launch from IDLE, count down in RUN, and commit HI/LO on the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU
`ifdef MULDIV_MADD_EN
                        , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                        : begin
                            op_d    = op;
                            a_d     = rs_data;
                            b_d     = rt_data;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = op;
                            a_d     = rs_data;
                            b_d     = rt_data;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        OP_MULT, OP_MULTU: begin
                            hi_d = prod[63:32];
                            lo_d = prod[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            hi_d = acc_add[63:32];
                            lo_d = acc_add[31:0];
                        end
                        OP_MSUB, OP_MSUBU: begin
                            hi_d = acc_sub[63:32];
                            lo_d = acc_sub[31:0];
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, operand latches and HI/LO. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mod_muldiv.sv
// tb_mod_muldiv: directed, table-driven bench for mod_muldiv, plus hand-written
// sequences for a start held during busy and for reset asserted mid-operation.
module tb_mod_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mod_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one start and count busy cycles, checking that HI/LO hold throughout.
    // If hold_div is set, start with op=DIV stays asserted for the whole busy period.
    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit hold_div, output int cyc);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        if (hold_div) begin
            op      = 4'd2;
            rs_data = 32'h0000_0064;
            rt_data = 32'h0000_0003;
        end else begin
            start   = 1'b0;
            rs_data = 32'hDEAD_BEEF;
            rt_data = 32'h0BAD_F00D;
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            chk({name, "_hold_hi"}, hi, h0);
            chk({name, "_hold_lo"}, lo, l0);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        start   = 1'b0;
        op      = 4'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        reset   = 1'b0;
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{"mult",    4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{"div_neg", 4'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"divu",    4'd3, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003});
        vecs.push_back('{"div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{"div_pn",  4'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{"mult_nn", 4'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5,  32'h0000_0000, 32'h0000_000C});
        vecs.push_back('{"mthi",    4'd4, 32'h1234_5678, 32'h0000_0000, 0,  32'h1234_5678, 32'h0000_000C});
        vecs.push_back('{"mtlo",    4'd5, 32'h9ABC_DEF0, 32'h0000_0000, 0,  32'h1234_5678, 32'h9ABC_DEF0});
        vecs.push_back('{"div_zero",4'd2, 32'h0000_0055, 32'h0000_0000, 10, 32'h1234_5678, 32'h9ABC_DEF0});
        vecs.push_back('{"rsvd",    4'd12,32'h1111_1111, 32'h2222_2222, 0,  32'h1234_5678, 32'h9ABC_DEF0});
        vecs.push_back('{"mthi0",   4'd4, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000, 32'h9ABC_DEF0});
        vecs.push_back('{"mtlo5",   4'd5, 32'h0000_0005, 32'h0000_0000, 0,  32'h0000_0000, 32'h0000_0005});
`ifdef MULDIV_MADD_EN
        vecs.push_back('{"madd",    4'd6, 32'h0000_0003, 32'h0000_0004, 5,  32'h0000_0000, 32'h0000_0011});
        vecs.push_back('{"msubu",   4'd9, 32'h0000_0001, 32'h0000_0012, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
`else
        vecs.push_back('{"madd",    4'd6, 32'h0000_0003, 32'h0000_0004, 0,  32'h0000_0000, 32'h0000_0005});
        vecs.push_back('{"msubu",   4'd9, 32'h0000_0001, 32'h0000_0012, 0,  32'h0000_0000, 32'h0000_0005});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, cyc);
            chk({vecs[i].name, "_busy_cycles"}, 32'(cyc), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            if (i == 0) begin
                // MULTU with start+DIV held during the whole busy period.
                run_op("multu_held", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, cyc);
                chk("multu_held_busy_cycles", 32'(cyc), 32'd5);
                chk("multu_held_hi", hi, 32'h0000_0001);
                chk("multu_held_lo", lo, 32'hFFFF_FFFE);
                repeat (3) @(posedge clk);
                #1;
                chk("multu_held_no_followon", {31'd0, busy}, 32'd0);
            end
        end

        // Reset during busy cycle 3 of a MULT: immediate clear, no later commit.
        @(negedge clk);
        start   = 1'b1;
        op      = 4'd0;
        rs_data = 32'hFFFF_FFFF;
        rt_data = 32'h0000_0002;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_muldiv.md
Name: mod_muldiv

Overview:
- Multi-cycle multiply/divide responder for the E stage of the pipeline.
- The E stage issues a one-cycle start with operation and operands. This block holds busy for a fixed latency, then commits HI/LO.
- busy feeds mod_hazard (mult_busy), which stalls any mult/div/mfhi/mflo issued while the unit is occupied.
- HI/LO are read back into E-stage result selection for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (and MADD/MSUB family when enabled); minimum 1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled on a rising clk edge.
- op  input  4  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 reserved.
- rs_data  input  32  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_data  input  32  operand B (divisor / multiplier).
- busy  output  1  unit occupied; new results pending.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, hi=0, lo=0, counter=0, latched operands discarded. Reset asserted mid-operation aborts it; HI/LO stay 0.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - busy is decoded from state only (registered, no combinational path from start).
- IDLE + start + op in {0,1,2,3} (and {6..9} when enabled):
  - Latch op, rs_data and rt_data.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - If start is sampled at edge T, busy=1 after edge T through edge T+N-1, i.e. exactly N cycles.
- RUN: counter decrements each edge. At the edge where counter==1: write hi/lo, go to IDLE, busy=0.
  - New HI/LO are therefore visible in the same cycle busy first reads 0.
  - HI/LO hold their old values for the whole RUN period.
- IDLE + start + MTHI/MTLO: hi (or lo) := rs_data at that edge; busy never asserts.
- start while in RUN, any op: ignored, no side effects. The hazard logic guarantees this does not occur; the bench still checks it.
- start with a reserved op, or an optional op when compiled out: no-op, busy stays 0.
- Arithmetic rules:
  - MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32x32 -> 64; same split.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Divide by zero: full DIV_CYCLES busy period, then hi/lo left unchanged.
- Results derive only from latched operands; input changes during RUN have no effect.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 6-9 are valid, with MULT_CYCLES latency. The 64-bit product (signed for 6/8, unsigned for 7/9) is added to (MADD/MADDU) or subtracted from (MSUB/MSUBU) {hi,lo}, sampled at commit time. The result wraps modulo 2^64.
- Not defined: ops 6-9 are treated as reserved no-ops, and no accumulate datapath is synthesized.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. During busy, hold start with op=DIV -> ignored; hi/lo and busy length unaffected.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1.
- MTHI rs=0x12345678, next cycle MTLO rs=0x9ABCDEF0 -> busy never rises; hi/lo updated on the sampling edges. Then DIV by rt=0 -> 10 busy cycles, hi/lo unchanged.
- Start MULT, assert reset at busy cycle 3 -> busy=0, hi=lo=0 immediately, without waiting for a clock edge; no later commit.
- With MULDIV_MADD_EN: MTHI 0, MTLO 5, then MADD rs=3 rt=4 -> lo=17, hi=0. MSUBU rs=1 rt=18 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Without the macro, the same ops leave hi/lo unchanged and busy=0.
